mem_access_stage: RTL and testbench

- Pipeline MEM stage of the 5-stage RV32 core.
- Consumes the ex_mem_reg struct from the EX/MEM buffer and produces the mem_wb_reg struct for writeback.
- Runs load/store accesses against a data memory with a req/ack handshake, so memory latency is variable.
- Formats byte and halfword lanes by func3, and stalls upstream while an access is outstanding.

---
 rtl/Pipe_Buf_Reg_PKG.sv | 67 ++++++
 rtl/ls_lane_align.sv | 55 +++++
 rtl/mem_access_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/Pipe_Buf_Reg_PKG.sv
// Pipeline buffer payload types and helpers shared by the RV32 pipeline stages.
// Also holds the MEM-stage state enum, func3 encodings and the misalignment predicate.
package Pipe_Buf_Reg_PKG;

    localparam int unsigned DMEM_ADDR_W = 9;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE, BUSY} mem_state_e;

    typedef struct packed {
        logic        RegWrite;
        logic [1:0]  MemtoReg;
        logic        MemRead;
        logic        MemWrite;
        logic [31:0] Pc_Imm;
        logic [31:0] Pc_Four;
        logic [31:0] Imm_Out;
        logic [31:0] Alu_Result;
        logic [31:0] RD_Two;
        logic [4:0]  rd;
        logic [2:0]  func3;
        logic [31:0] Curr_Instr;
    } ex_mem_reg;

    typedef struct packed {
        logic        RegWrite;
        logic [1:0]  MemtoReg;
        logic [31:0] Pc_Imm;
        logic [31:0] Pc_Four;
        logic [31:0] Imm_Out;
        logic [31:0] Alu_Result;
        logic [31:0] MemReadData;
        logic [4:0]  rd;
        logic [31:0] Curr_Instr;
    } mem_wb_reg;

    function automatic mem_wb_reg to_mem_wb(input ex_mem_reg e, input logic [31:0] rd_data);
        mem_wb_reg w;
        w.RegWrite    = e.RegWrite;
        w.MemtoReg    = e.MemtoReg;
        w.Pc_Imm      = e.Pc_Imm;
        w.Pc_Four     = e.Pc_Four;
        w.Imm_Out     = e.Imm_Out;
        w.Alu_Result  = e.Alu_Result;
        w.MemReadData = rd_data;
        w.rd          = e.rd;
        w.Curr_Instr  = e.Curr_Instr;
        return w;
    endfunction

    // Halfword with odd offset, or word with any non-zero offset.
    function automatic logic is_misaligned(input ex_mem_reg e);
        logic [1:0] off;
        logic       half;
        logic       word;
        off  = e.Alu_Result[1:0];
        half = (e.func3 == F3_H) || (!e.MemWrite && (e.func3 == F3_HU));
        word = (e.func3 == F3_W);
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/ls_lane_align.sv
// Byte/halfword lane steering for the MEM stage: store byte enables and data
// replication, plus load lane extraction with sign/zero extension by func3.
module ls_lane_align
    import Pipe_Buf_Reg_PKG::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        unique case (off)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
        endcase
        half_lane = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (func3)
            F3_B: begin
                be    = 4'b0001 << off;
                wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
                be    = 4'b0011 << {off[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        case (func3)
            F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   load_data = {24'd0, byte_lane};
            F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
            F3_HU:   load_data = {16'd0, half_lane};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32 MEM stage: runs loads/stores over a req/ack data-memory port and registers MEM/WB.
// Optional macro MEM_MISALIGN_CHECK_EN adds the misalign output and suppresses misaligned accesses.
module mem_access_stage
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  ex_mem_reg         mem_in,
    input  logic              in_valid,
    output logic              stall,
    output mem_wb_reg         mem_out,
    output logic              out_valid,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    typedef enum logic [1:0] {SrcNone, SrcAck, SrcPend, SrcNew} out_src_e;

    mem_state_e state_q, state_d;
    ex_mem_reg  cap_q, cap_d;
    mem_wb_reg  mem_out_q, mem_out_d;
    mem_wb_reg  pend_q, pend_d;
    logic       out_valid_q, pend_valid_q, pend_load;
    out_src_e   out_src;

    logic       busy, accept, ack_edge, mem_op_in, mis_in, go_busy, pass_new;
    logic [3:0] lane_be;
    logic [31:0] lane_wdata, lane_load;
    mem_wb_reg  pass_word, ack_word;

    assign busy      = (state_q == BUSY);
    assign stall     = busy & ~dmem_ack;
    assign accept    = in_valid & ~stall;
    assign ack_edge  = busy & dmem_ack;
    assign mem_op_in = mem_in.MemRead | mem_in.MemWrite;

`ifdef MEM_MISALIGN_CHECK_EN
    assign mis_in = mem_op_in & is_misaligned(mem_in);
`else
    assign mis_in = 1'b0;
`endif

    // Misaligned ops complete like pass-through ops and never touch memory.
    assign go_busy  = accept & mem_op_in & ~mis_in;
    assign pass_new = accept & ~go_busy;

    ls_lane_align u_lane (
        .func3      (cap_q.func3),
        .off        (cap_q.Alu_Result[1:0]),
        .store_data (cap_q.RD_Two),
        .rdata      (dmem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    assign dmem_req   = busy;
    assign dmem_we    = busy & cap_q.MemWrite;
    assign dmem_addr  = {cap_q.Alu_Result[ADDR_W-1:2], 2'b00};
    assign dmem_wdata = lane_wdata;
    assign dmem_be    = busy ? (cap_q.MemWrite ? lane_be : 4'b1111) : 4'b0000;

    always_comb begin
        pass_word          = to_mem_wb(mem_in, 32'd0);
        pass_word.RegWrite = mem_in.RegWrite & ~mis_in;
        ack_word           = to_mem_wb(cap_q, (cap_q.MemRead & ~cap_q.MemWrite) ? lane_load : 32'd0);
    end

    // A pass-through op accepted on an ack edge (or behind one) waits one cycle in pend_q,
    // keeping the output rate at one per cycle without stalling upstream.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        if (go_busy) begin
            state_d = BUSY;
            cap_d   = mem_in;
        end else if (ack_edge) begin
            state_d = IDLE;
        end

        if (ack_edge) begin
            out_src = SrcAck;
        end else if (pend_valid_q) begin
            out_src = SrcPend;
        end else if (pass_new) begin
            out_src = SrcNew;
        end else begin
            out_src = SrcNone;
        end

        pend_load = pass_new & (out_src != SrcNew);
        pend_d    = pend_load ? pass_word : pend_q;

        unique case (out_src)
            SrcAck:  mem_out_d = ack_word;
            SrcPend: mem_out_d = pend_q;
            SrcNew:  mem_out_d = pass_word;
            SrcNone: mem_out_d = mem_out_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cap_q        <= '0;
            mem_out_q    <= '0;
            out_valid_q  <= 1'b0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cap_q        <= cap_d;
            mem_out_q    <= mem_out_d;
            out_valid_q  <= (out_src != SrcNone);
            pend_q       <= pend_d;
            pend_valid_q <= pend_load;
        end
    end

    always_comb begin
        mem_out          = mem_out_q;
        mem_out.RegWrite = mem_out_q.RegWrite & out_valid_q;
    end

    assign out_valid = out_valid_q;

`ifdef MEM_MISALIGN_CHECK_EN
    logic out_mis_q, pend_mis_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_mis_q  <= 1'b0;
            pend_mis_q <= 1'b0;
        end else begin
            if (pend_load) begin
                pend_mis_q <= mis_in;
            end
            unique case (out_src)
                SrcPend: out_mis_q <= pend_mis_q;
                SrcNew:  out_mis_q <= mis_in;
                SrcAck:  out_mis_q <= 1'b0;
                SrcNone: out_mis_q <= 1'b0;
            endcase
        end
    end

    assign misalign = out_mis_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: randomized and directed loads/stores against a
// byte-array memory model, with a variable-latency req/ack memory responder.
module tb_mem_access_stage;
    import Pipe_Buf_Reg_PKG::*;

    localparam int unsigned AW = DMEM_ADDR_W;

    logic            clk = 1'b0;
    logic            reset;
    ex_mem_reg       mem_in;
    logic            in_valid;
    logic            stall;
    mem_wb_reg       mem_out;
    logic            out_valid;
    logic            dmem_req;
    logic            dmem_we;
    logic [AW-1:0]   dmem_addr;
    logic [31:0]     dmem_wdata;
    logic [3:0]      dmem_be;
    logic [31:0]     dmem_rdata;
    logic            dmem_ack;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [3:0]    be;
        logic [31:0]   wdata;
    } acc_t;

    mem_wb_reg   exp_q[$];
    acc_t        acc_q[$];
    logic [31:0] mem_words [128];
    logic [7:0]  ref_mem [512];
    int          checks = 0;
    int          errors = 0;
    int          fixed_lat = -1;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk        (clk),
        .reset      (reset),
        .mem_in     (mem_in),
        .in_valid   (in_valid),
        .stall      (stall),
        .mem_out    (mem_out),
        .out_valid  (out_valid),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack)
    );

    task automatic chk(input bit ok, input string msg);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s", msg);
        end
    endtask

    function automatic int access_size(input logic [2:0] f3, input bit store);
        if (f3 == 3'b000 || (!store && f3 == 3'b100)) return 1;
        if (f3 == 3'b001 || (!store && f3 == 3'b101)) return 2;
        return 4;
    endfunction

    // Reference model: byte-addressed memory, updated in program order.
    function automatic mem_wb_reg model(input ex_mem_reg t);
        mem_wb_reg   w;
        int          a, size, base;
        logic [31:0] v;
        w = to_mem_wb(t, 32'd0);
        a = int'(t.Alu_Result[AW-1:0]);
        if (t.MemWrite) begin
            size = access_size(t.func3, 1'b1);
            base = a - (a % size);
            for (int j = 0; j < size; j++) ref_mem[base + j] = t.RD_Two[8*j +: 8];
        end else if (t.MemRead) begin
            size = access_size(t.func3, 1'b0);
            base = a - (a % size);
            v = 32'd0;
            for (int j = 0; j < size; j++) v[8*j +: 8] = ref_mem[base + j];
            if (t.func3 == 3'b000 && v[7]) v[31:8] = '1;
            if (t.func3 == 3'b001 && v[15]) v[31:16] = '1;
            w.MemReadData = v;
        end
        return w;
    endfunction

    function automatic acc_t exp_access(input ex_mem_reg t);
        acc_t e;
        int   a, size, lo;
        a    = int'(t.Alu_Result[AW-1:0]);
        size = access_size(t.func3, 1'b1);
        lo   = (a % 4) - ((a % 4) % size);
        e.addr  = AW'(a - (a % 4));
        e.we    = t.MemWrite;
        e.be    = 4'b0000;
        e.wdata = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (k >= lo && k < lo + size) e.be[k] = 1'b1;
            e.wdata[8*k +: 8] = t.RD_Two[8*(k % size) +: 8];
        end
        return e;
    endfunction

    function automatic ex_mem_reg rand_instr();
        ex_mem_reg t;
        int        k;
        t.RegWrite   = 1'($urandom);
        t.MemtoReg   = 2'($urandom);
        t.Pc_Imm     = $urandom;
        t.Pc_Four    = $urandom;
        t.Imm_Out    = $urandom;
        t.Alu_Result = $urandom;
        t.RD_Two     = $urandom;
        t.rd         = 5'($urandom);
        t.func3      = 3'($urandom);
        t.Curr_Instr = $urandom;
        k = $urandom_range(0, 99);
        t.MemRead    = (k >= 30 && k < 65) || (k >= 95);
        t.MemWrite   = (k >= 65);
        return t;
    endfunction

    function automatic ex_mem_reg mk(input bit rd_en, input bit wr_en, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] data);
        ex_mem_reg t;
        t = rand_instr();
        t.MemRead    = rd_en;
        t.MemWrite   = wr_en;
        t.func3      = f3;
        t.Alu_Result = addr;
        t.RD_Two     = data;
        t.RegWrite   = 1'b1;
        return t;
    endfunction

    task automatic set_word(input int idx, input logic [31:0] v);
        mem_words[idx] = v;
        for (int j = 0; j < 4; j++) ref_mem[4*idx + j] = v[8*j +: 8];
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input ex_mem_reg t, input int gap, output int waits,
                         output int req_low, output logic req_after);
        int guard;
        waits = 0;
        req_low = 0;
        guard = 0;
        req_after = 1'b0;
        mem_in = t;
        in_valid = 1'b1;
        while (stall && guard < 200) begin
            @(negedge clk);
            guard++;
            waits++;
            if (!dmem_req) req_low++;
        end
        if (stall) begin
            chk(1'b0, $sformatf("accept_timeout stall=%b after %0d cycles required 0", stall, guard));
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(t));
        if (t.MemRead || t.MemWrite) acc_q.push_back(exp_access(t));
        @(negedge clk);
        req_after = dmem_req;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || acc_q.size() != 0) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk(exp_q.size() == 0 && acc_q.size() == 0,
            $sformatf("drain pending_outputs=%0d pending_accesses=%0d required 0 0",
                      exp_q.size(), acc_q.size()));
        @(negedge clk);
    endtask

    // Memory responder: ack earliest one cycle after req is first seen.
    initial begin
        int lat;
        bit active;
        bit acked;
        int idx;
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        active = 1'b0;
        lat = 0;
        forever begin
            @(posedge clk);
            acked = dmem_ack;
            #1;
            dmem_ack = 1'b0;
            if (acked || !reset) active = 1'b0;
            if (reset && dmem_req) begin
                if (!active) begin
                    active = 1'b1;
                    lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
                end else if (lat > 0) begin
                    lat--;
                end else begin
                    dmem_ack = 1'b1;
                    idx = int'(dmem_addr[AW-1:2]);
                    if (dmem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (dmem_be[b]) mem_words[idx][8*b +: 8] = dmem_wdata[8*b +: 8];
                    end else begin
                        dmem_rdata = mem_words[idx];
                    end
                end
            end
        end
    end

    // Output and access monitor.
    initial begin
        mem_wb_reg e;
        acc_t      a;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, $sformatf("unexpected_output got %h required none", mem_out));
                    end else begin
                        e = exp_q.pop_front();
                        chk(mem_out === e, $sformatf("mem_out got %h required %h", mem_out, e));
                    end
                end else begin
                    chk(mem_out.RegWrite === 1'b0,
                        $sformatf("idle_regwrite got %b required 0", mem_out.RegWrite));
                end
                if (dmem_req && dmem_ack) begin
                    if (acc_q.size() == 0) begin
                        chk(1'b0, $sformatf("unexpected_access got addr %h required none",
                                            dmem_addr));
                    end else begin
                        a = acc_q.pop_front();
                        chk(dmem_addr === a.addr && dmem_we === a.we,
                            $sformatf("access addr/we got %h/%b required %h/%b",
                                      dmem_addr, dmem_we, a.addr, a.we));
                        if (a.we)
                            chk(dmem_be === a.be && dmem_wdata === a.wdata,
                                $sformatf("store be/wdata got %b/%h required %b/%h",
                                          dmem_be, dmem_wdata, a.be, a.wdata));
                    end
                end
            end
        end
    end

    initial begin
        ex_mem_reg t;
        int        w, rl, w2, rl2;
        logic      ra, ra2;

        reset = 1'b0;
        in_valid = 1'b0;
        mem_in = '0;
        for (int i = 0; i < 128; i++) set_word(i, $urandom);

        repeat (2) @(negedge clk);
        chk(out_valid === 1'b0, $sformatf("reset_out_valid got %b required 0", out_valid));
        chk(dmem_req === 1'b0, $sformatf("reset_req got %b required 0", dmem_req));
        chk(stall === 1'b0, $sformatf("reset_stall got %b required 0", stall));
        chk(dmem_we === 1'b0, $sformatf("reset_we got %b required 0", dmem_we));
        chk(dmem_be === 4'b0000, $sformatf("reset_be got %b required 0000", dmem_be));
        chk(mem_out === '0, $sformatf("reset_mem_out got %h required 0", mem_out));
        reset = 1'b1;
        @(negedge clk);

        // Pass-through op: one-cycle latency, no memory traffic.
        t = mk(1'b0, 1'b0, 3'b000, 32'h55, 32'h0);
        issue(t, 0, w, rl, ra);
        chk(out_valid === 1'b1, $sformatf("add_latency out_valid got %b required 1", out_valid));
        chk(ra === 1'b0 && w == 0, $sformatf("add_no_req req=%b stall_cycles=%0d required 0 0",
                                             ra, w));
        repeat (2) @(negedge clk);

        // SB with ack two cycles after the first req cycle; the follower sees two stall cycles.
        fixed_lat = 1;
        issue(mk(1'b0, 1'b1, 3'b000, 32'h007, 32'h0000_00A5), 0, w, rl, ra);
        issue(mk(1'b0, 1'b0, 3'b000, 32'h99, 32'h0), 0, w, rl, ra);
        chk(w == 2, $sformatf("sb_stall_cycles got %0d required 2", w));
        drain();

        // Lane extraction with immediate ack.
        fixed_lat = 0;
        set_word(1, 32'h12F0_3456);
        issue(mk(1'b1, 1'b0, 3'b000, 32'h006, 32'h0), 1, w, rl, ra);
        issue(mk(1'b1, 1'b0, 3'b100, 32'h006, 32'h0), 1, w, rl, ra);
        issue(mk(1'b1, 1'b0, 3'b101, 32'h006, 32'h0), 1, w, rl, ra);
        issue(mk(1'b1, 1'b0, 3'b001, 32'h006, 32'h0), 1, w, rl, ra);
        drain();

        // Back-to-back LW then SW: second accepted on the ack edge, req never drops.
        fixed_lat = -1;
        issue(mk(1'b1, 1'b0, 3'b010, 32'h010, 32'h0), 0, w, rl, ra);
        issue(mk(1'b0, 1'b1, 3'b010, 32'h014, $urandom), 0, w2, rl2, ra2);
        chk(ra === 1'b1 && rl2 == 0 && ra2 === 1'b1,
            $sformatf("b2b_req_continuous got req1=%b lows=%0d req2=%b required 1 0 1",
                      ra, rl2, ra2));
        drain();

        // Reset while an access is outstanding discards it.
        fixed_lat = 8;
        mem_in = mk(1'b1, 1'b0, 3'b010, 32'h020, 32'h0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk(dmem_req === 1'b1, $sformatf("busy_req got %b required 1", dmem_req));
        #2;
        reset = 1'b0;
        #1;
        chk(dmem_req === 1'b0 && out_valid === 1'b0 && stall === 1'b0,
            $sformatf("midreset req/out_valid/stall got %b/%b/%b required 0/0/0",
                      dmem_req, out_valid, stall));
        @(negedge clk);
        reset = 1'b1;
        fixed_lat = -1;
        @(negedge clk);
        issue(mk(1'b1, 1'b0, 3'b010, 32'h024, 32'h0), 0, w, rl, ra);
        drain();

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            issue(rand_instr(), $urandom_range(0, 2), w, rl, ra);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
